// File: rtl/column_scan_scheduler.sv
// column_scan_scheduler: slice-aligned, flow-controlled scan of column pairs
// (c, c+SCAN_RATE) feeding the HUB75 driver.
// Ports: clk_in, rst_n_in (async, active-low); dtheta, mode_req, col_mask in;
//   hub75_ready / hub75_last handshake in; col_num1, col_num2, mode_active,
//   data_valid to the source mux; busy, theta_done, overrun status pulses.
// Option: define SCANLINE_SKIP_EN to skip pairs absent from col_mask.
module column_scan_scheduler #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int NUM_COLS       = 64,
    parameter int SCAN_RATE      = 32,
    parameter int SRC_LATENCY    = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    input  logic [1:0]                        mode_req,
    input  logic [NUM_COLS-1:0]               col_mask,
    input  logic                              hub75_ready,
    input  logic                              hub75_last,
    output logic [$clog2(SCAN_RATE)-1:0]      col_num1,
    output logic [$clog2(SCAN_RATE):0]        col_num2,
    output logic [1:0]                        mode_active,
    output logic                              data_valid,
    output logic                              busy,
    output logic                              theta_done,
    output logic                              overrun
);

    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int CW = $clog2(SCAN_RATE);
    localparam logic [CW-1:0] LAST_C = CW'(SCAN_RATE - 1);
    localparam logic [CW:0]   C2_OFF = (CW + 1)'(SCAN_RATE);
    localparam logic [2:0]    LAT    = 3'(SRC_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SRC,
        S_PRESENT,
        S_WAIT_LAST,
        S_DONE
    } state_t;

    state_t        r_state, w_state_d;
    logic [TW-1:0] r_last_theta, w_theta_d;
    logic          r_first, w_first_d;
    logic [1:0]    r_mode, w_mode_d;
    logic [CW-1:0] r_ptr, w_ptr_d;
    logic [CW-1:0] r_col1, w_col1_d;
    logic [CW:0]   r_col2, w_col2_d;
    logic [2:0]    r_lat, w_lat_d;
    logic          r_valid, w_valid_d;
    logic          r_restart, w_restart_d;

    logic          w_chg;
    logic          w_found;
    logic [CW-1:0] w_sel;

    assign w_chg = (dtheta != r_last_theta);

`ifdef SCANLINE_SKIP_EN
    logic [SCAN_RATE-1:0] w_pair;
    assign w_pair = col_mask[SCAN_RATE-1:0] | col_mask[NUM_COLS-1:SCAN_RATE];

    // lowest qualifying pair at or above the scan pointer
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = SCAN_RATE - 1; i >= 0; i--) begin
            if (w_pair[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_sel   = CW'(i);
            end
        end
    end
`else
    logic w_unused_mask;
    assign w_unused_mask = ^col_mask;
    assign w_found = 1'b1;
    assign w_sel   = r_ptr;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_last_theta <= '0;
            r_first      <= 1'b1;
            r_mode       <= '0;
            r_ptr        <= '0;
            r_col1       <= '0;
            r_col2       <= '0;
            r_lat        <= '0;
            r_valid      <= 1'b0;
            r_restart    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_last_theta <= w_theta_d;
            r_first      <= w_first_d;
            r_mode       <= w_mode_d;
            r_ptr        <= w_ptr_d;
            r_col1       <= w_col1_d;
            r_col2       <= w_col2_d;
            r_lat        <= w_lat_d;
            r_valid      <= w_valid_d;
            r_restart    <= w_restart_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_theta_d   = r_last_theta;
        w_first_d   = r_first;
        w_mode_d    = r_mode;
        w_ptr_d     = r_ptr;
        w_col1_d    = r_col1;
        w_col2_d    = r_col2;
        w_lat_d     = r_lat;
        w_valid_d   = r_valid;
        w_restart_d = r_restart;
        unique case (r_state)
            S_IDLE: begin
                if (r_first || w_chg) begin
                    w_theta_d = dtheta;
                    w_mode_d  = mode_req;
                    w_ptr_d   = '0;
                    w_first_d = 1'b0;
                    w_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_chg) begin
                    w_theta_d = dtheta;
                    w_mode_d  = mode_req;
                    w_ptr_d   = '0;
                end else if (!w_found) begin
                    w_state_d = S_DONE;
                end else begin
                    w_col1_d  = w_sel;
                    w_col2_d  = {1'b0, w_sel} + C2_OFF;
                    w_lat_d   = LAT;
                    w_state_d = S_WAIT_SRC;
                end
            end
            S_WAIT_SRC: begin
                if (w_chg) begin
                    w_theta_d = dtheta;
                    w_mode_d  = mode_req;
                    w_ptr_d   = '0;
                    w_state_d = S_ISSUE;
                end else begin
                    w_lat_d = r_lat - 3'd1;
                    if (r_lat == 3'd1) begin
                        w_valid_d = 1'b1;
                        w_state_d = S_PRESENT;
                    end
                end
            end
            S_PRESENT: begin
                // the driver owns the pair; remember the change, restart later
                if (w_chg) begin
                    w_theta_d   = dtheta;
                    w_restart_d = 1'b1;
                end
                if (r_valid && hub75_ready) begin
                    w_valid_d = 1'b0;
                    w_state_d = S_WAIT_LAST;
                end
            end
            S_WAIT_LAST: begin
                if (w_chg) begin
                    w_theta_d   = dtheta;
                    w_restart_d = 1'b1;
                end
                if (hub75_last) begin
                    if (r_restart || w_chg) begin
                        w_mode_d    = mode_req;
                        w_ptr_d     = '0;
                        w_restart_d = 1'b0;
                        w_state_d   = S_ISSUE;
                    end else if (r_col1 == LAST_C) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_ptr_d   = r_col1 + CW'(1);
                        w_state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign col_num1    = r_col1;
    assign col_num2    = r_col2;
    assign mode_active = r_mode;
    assign data_valid  = r_valid;
    assign busy        = (r_state != S_IDLE);
    assign theta_done  = (r_state == S_DONE);
    assign overrun     = w_chg && (r_state inside
                         {S_ISSUE, S_WAIT_SRC, S_PRESENT, S_WAIT_LAST});

endmodule

// File: tb/tb_column_scan_scheduler.sv
// tb_column_scan_scheduler: directed bench for column_scan_scheduler.
// Covers reset, full scan, ready stall, mode latch, overrun, skip, async reset.
module tb_column_scan_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [9:0]  dtheta;
    logic [1:0]  mode_req;
    logic [63:0] col_mask;
    logic        hub75_ready;
    logic        hub75_last;
    logic [4:0]  col_num1;
    logic [5:0]  col_num2;
    logic [1:0]  mode_active;
    logic        data_valid;
    logic        busy;
    logic        theta_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_ovr  = 0;

    column_scan_scheduler dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .dtheta      (dtheta),
        .mode_req    (mode_req),
        .col_mask    (col_mask),
        .hub75_ready (hub75_ready),
        .hub75_last  (hub75_last),
        .col_num1    (col_num1),
        .col_num2    (col_num2),
        .mode_active (mode_active),
        .data_valid  (data_valid),
        .busy        (busy),
        .theta_done  (theta_done),
        .overrun     (overrun)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (theta_done === 1'b1) n_done++;
        if (overrun === 1'b1) n_ovr++;
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (data_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // called at the negedge where data_valid is seen with ready high
    task automatic serve_tail();
        @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        hub75_last = 1'b1;
        @(negedge clk_in);
        hub75_last = 1'b0;
    endtask

    task automatic finish_scan(input int from);
        bit ok;
        bit seen;
        for (int i = from; i < 32; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok || col_num1 !== 5'(i) || col_num2 !== 6'(i + 32)) begin
                errors++;
                $display("FAIL pair%0d ok=%0d got c1=%0d c2=%0d want %0d %0d",
                         i, ok, col_num1, col_num2, i, i + 32);
            end
            serve_tail();
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (theta_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL scan_done got none want theta_done");
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        int cnt;
        int snap;
        rst_n_in    = 1'b0;
        dtheta      = 10'd0;
        mode_req    = 2'd0;
        col_mask    = '1;
        hub75_ready = 1'b1;
        hub75_last  = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({col_num1, col_num2, mode_active, data_valid,
             busy, theta_done, overrun} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0",
                     {col_num1, col_num2, mode_active, data_valid,
                      busy, theta_done, overrun});
        end
        snap = n_done;
        rst_n_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            cnt++;
            if (data_valid === 1'b1) break;
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL first_valid_lat got %0d want 4", cnt);
        end
        checks++;
        if (col_num1 !== 5'd0 || col_num2 !== 6'd32) begin
            errors++;
            $display("FAIL first_cols got %0d %0d want 0 32",
                     col_num1, col_num2);
        end
        serve_tail();
        finish_scan(1);
        checks++;
        if (n_done - snap != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_scan_end got done=%0d busy=%0d want 1 0",
                     n_done - snap, busy);
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        bit bad;
        hub75_ready = 1'b0;
        dtheta = 10'd1;
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd0) begin
            errors++;
            $display("FAIL stall_start ok=%0d got c1=%0d want 0", ok, col_num1);
        end
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (data_valid !== 1'b1 || col_num1 !== 5'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold got dv=%0d c1=%0d want 1 0",
                     data_valid, col_num1);
        end
        hub75_ready = 1'b1;
        @(negedge clk_in);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_xfer got dv=%0d want 0", data_valid);
        end
        repeat (2) @(negedge clk_in);
        checks++;
        if (data_valid !== 1'b0 || col_num1 !== 5'd0) begin
            errors++;
            $display("FAIL stall_once got dv=%0d c1=%0d want 0 0",
                     data_valid, col_num1);
        end
        hub75_last = 1'b1;
        @(negedge clk_in);
        hub75_last = 1'b0;
        finish_scan(1);
    endtask

    task automatic test_mode_latch();
        bit ok;
        mode_req = 2'd1;
        dtheta = 10'd2;
        wait_valid(ok);
        checks++;
        if (!ok || mode_active !== 2'd1) begin
            errors++;
            $display("FAIL mode_first got %0d want 1", mode_active);
        end
        serve_tail();
        mode_req = 2'd3;
        wait_valid(ok);
        checks++;
        if (!ok || mode_active !== 2'd1 || col_num1 !== 5'd1) begin
            errors++;
            $display("FAIL mode_hold got m=%0d c1=%0d want 1 1",
                     mode_active, col_num1);
        end
        serve_tail();
        finish_scan(2);
        checks++;
        if (mode_active !== 2'd1) begin
            errors++;
            $display("FAIL mode_idle got %0d want 1", mode_active);
        end
        dtheta = 10'd3;
        wait_valid(ok);
        checks++;
        if (!ok || mode_active !== 2'd3 || col_num1 !== 5'd0) begin
            errors++;
            $display("FAIL mode_new got m=%0d c1=%0d want 3 0",
                     mode_active, col_num1);
        end
        serve_tail();
        finish_scan(1);
    endtask

    task automatic test_overrun();
        bit ok;
        int snap_done;
        int snap_ovr;
        mode_req = 2'd2;
        dtheta = 10'd4;
        for (int i = 0; i < 7; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok || col_num1 !== 5'(i)) begin
                errors++;
                $display("FAIL ovr_pair%0d got %0d want %0d", i, col_num1, i);
            end
            serve_tail();
        end
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd7) begin
            errors++;
            $display("FAIL ovr_pair7 got %0d want 7", col_num1);
        end
        snap_done = n_done;
        @(negedge clk_in);
        mode_req = 2'd1;
        dtheta = 10'd5;
        #1;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse got %0d want 1", overrun);
        end
        @(negedge clk_in);
        snap_ovr = n_ovr;
        checks++;
        if (overrun !== 1'b0 || data_valid !== 1'b0 || mode_active !== 2'd2) begin
            errors++;
            $display("FAIL ovr_hold got ovr=%0d dv=%0d m=%0d want 0 0 2",
                     overrun, data_valid, mode_active);
        end
        hub75_last = 1'b1;
        @(negedge clk_in);
        hub75_last = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd0 || mode_active !== 2'd1) begin
            errors++;
            $display("FAIL ovr_restart got c1=%0d m=%0d want 0 1",
                     col_num1, mode_active);
        end
        checks++;
        if (n_done != snap_done) begin
            errors++;
            $display("FAIL ovr_no_done got %0d want 0", n_done - snap_done);
        end
        serve_tail();
        finish_scan(1);
        checks++;
        if (n_ovr != snap_ovr) begin
            errors++;
            $display("FAIL ovr_once got %0d extra want 0", n_ovr - snap_ovr);
        end
    endtask

`ifdef SCANLINE_SKIP_EN
    task automatic test_skip();
        bit ok;
        bit seen;
        bit saw_dv;
        col_mask = 64'h0000_0100_0000_0008;
        dtheta = 10'd6;
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd3 || col_num2 !== 6'd35) begin
            errors++;
            $display("FAIL skip_p3 got %0d %0d want 3 35", col_num1, col_num2);
        end
        serve_tail();
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd8 || col_num2 !== 6'd40) begin
            errors++;
            $display("FAIL skip_p8 got %0d %0d want 8 40", col_num1, col_num2);
        end
        serve_tail();
        seen = 1'b0;
        saw_dv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (data_valid === 1'b1) saw_dv = 1'b1;
            if (theta_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        checks++;
        if (!seen || saw_dv) begin
            errors++;
            $display("FAIL skip_end got done=%0d dv=%0d want 1 0", seen, saw_dv);
        end
        col_mask = '0;
        dtheta = 10'd7;
        seen = 1'b0;
        saw_dv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (data_valid === 1'b1) saw_dv = 1'b1;
            if (theta_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || saw_dv) begin
            errors++;
            $display("FAIL skip_zero got done=%0d dv=%0d want 1 0", seen, saw_dv);
        end
        @(negedge clk_in);
        col_mask = '1;
    endtask
`else
    task automatic test_skip();
        bit ok;
        col_mask = '0;
        dtheta = 10'd6;
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd0 || col_num2 !== 6'd32) begin
            errors++;
            $display("FAIL noskip_p0 got %0d %0d want 0 32", col_num1, col_num2);
        end
        serve_tail();
        finish_scan(1);
        col_mask = '1;
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        hub75_ready = 1'b0;
        mode_req = 2'd3;
        dtheta = 10'd8;
        wait_valid(ok);
        checks++;
        if (!ok || mode_active !== 2'd3) begin
            errors++;
            $display("FAIL rmid_present ok=%0d m=%0d want 1 3", ok, mode_active);
        end
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({col_num1, col_num2, mode_active, data_valid,
             busy, theta_done, overrun} !== 15'd0) begin
            errors++;
            $display("FAIL rmid_outs got %h want 0",
                     {col_num1, col_num2, mode_active, data_valid,
                      busy, theta_done, overrun});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        hub75_ready = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok || col_num1 !== 5'd0 || mode_active !== 2'd3) begin
            errors++;
            $display("FAIL rmid_restart got c1=%0d m=%0d want 0 3",
                     col_num1, mode_active);
        end
        serve_tail();
        finish_scan(1);
    endtask

    initial begin
        test_reset();
        test_ready_stall();
        test_mode_latch();
        test_overrun();
        test_skip();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
